stage4_alu_seq: RTL



---
 rtl/stage4_alu_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/stage4_alu_seq.sv
// Byte-serial multi-byte ALU stage: walks two little-endian operand strings in the
// 64x8 register file and writes the result string back. Optional SUB via STAGE4_SUB_EN.
module stage4_alu_seq (
   input  logic        ram_clk,
   input  logic        rst,
   input  logic        stage4_exec,
   output logic        stage4_exec_ready,
   input  logic [4:0]  stage4_oper,
   input  logic [15:0] stage4_source_a_start,
   input  logic [15:0] stage4_source_b_start,
   input  logic [15:0] stage4_target_register_start,
   input  logic [15:0] stage4_length,
   output logic [5:0]  reg_rd_addr_a,
   output logic [5:0]  reg_rd_addr_b,
   input  logic [7:0]  reg_rd_data_a,
   input  logic [7:0]  reg_rd_data_b,
   output logic        reg_wr_en,
   output logic [5:0]  reg_wr_addr,
   output logic [7:0]  reg_wr_data,
   output logic        stage4_carry,
   output logic        stage4_zero,
   output logic        stage4_error
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [4:0] OP_ADD = 5'd1;
   localparam logic [4:0] OP_SUB = 5'd2;
   localparam logic [4:0] OP_AND = 5'd3;
   localparam logic [4:0] OP_OR  = 5'd4;
   localparam logic [4:0] OP_XOR = 5'd5;

   state_t     state;
   logic [4:0] oper_q;
   logic [5:0] a_ptr;
   logic [5:0] b_ptr;
   logic [5:0] t_ptr;
   logic [6:0] remaining;
   logic       carry_q;
   logic       zero_q;
   logic       error_q;
   logic       ready_q;

   logic [7:0] alu_result;
   logic       alu_carry;
   logic [8:0] sum9;
   logic       op_legal;
   logic [6:0] len_clamped;

   // Only the low six bits of the start addresses address the register file
   logic unused_start_bits;
   assign unused_start_bits = ^{stage4_source_a_start[15:6],
                                stage4_source_b_start[15:6],
                                stage4_target_register_start[15:6]};

   assign len_clamped = (stage4_length > 16'd64) ? 7'd64 : stage4_length[6:0];

   always_comb begin
      op_legal = 1'b0;
      case (stage4_oper)
         OP_ADD, OP_AND, OP_OR, OP_XOR: op_legal = 1'b1;
`ifdef STAGE4_SUB_EN
         OP_SUB:                        op_legal = 1'b1;
`endif
         default:                       op_legal = 1'b0;
      endcase
   end

   // The carry/borrow chain is carried in carry_q between bytes; logic ops clear it
   always_comb begin
      alu_result = 8'h00;
      alu_carry  = 1'b0;
      sum9       = 9'h000;
      case (oper_q)
         OP_ADD: begin
            sum9       = {1'b0, reg_rd_data_a} + {1'b0, reg_rd_data_b} + {8'h00, carry_q};
            alu_result = sum9[7:0];
            alu_carry  = sum9[8];
         end
`ifdef STAGE4_SUB_EN
         OP_SUB: begin
            sum9       = {1'b0, reg_rd_data_a} - {1'b0, reg_rd_data_b} - {8'h00, carry_q};
            alu_result = sum9[7:0];
            alu_carry  = sum9[8];
         end
`endif
         OP_AND: alu_result = reg_rd_data_a & reg_rd_data_b;
         OP_OR:  alu_result = reg_rd_data_a | reg_rd_data_b;
         OP_XOR: alu_result = reg_rd_data_a ^ reg_rd_data_b;
         default: ;
      endcase
   end

   always_ff @(posedge ram_clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         oper_q    <= 5'd0;
         a_ptr     <= 6'd0;
         b_ptr     <= 6'd0;
         t_ptr     <= 6'd0;
         remaining <= 7'd0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
         error_q   <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (stage4_exec) begin
                  oper_q    <= stage4_oper;
                  a_ptr     <= stage4_source_a_start[5:0];
                  b_ptr     <= stage4_source_b_start[5:0];
                  t_ptr     <= stage4_target_register_start[5:0];
                  remaining <= len_clamped;
                  carry_q   <= 1'b0;
                  zero_q    <= 1'b1;
                  error_q   <= 1'b0;
                  if (!op_legal) begin
                     error_q <= 1'b1;
                     ready_q <= 1'b1;
                     state   <= DONE;
                  end else if (len_clamped == 7'd0) begin
                     ready_q <= 1'b1;
                     state   <= DONE;
                  end else begin
                     state   <= RUN;
                  end
               end
            end
            RUN: begin
               a_ptr     <= a_ptr + 6'd1;
               b_ptr     <= b_ptr + 6'd1;
               t_ptr     <= t_ptr + 6'd1;
               remaining <= remaining - 7'd1;
               carry_q   <= alu_carry;
               zero_q    <= zero_q & (alu_result == 8'h00);
               if (remaining == 7'd1) begin
                  ready_q <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (!stage4_exec) begin
                  ready_q <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Writes are combinational so the byte lands on the same edge that retires it,
   // letting the next byte's read observe it when targets overlap forward
   assign reg_wr_en         = (state == RUN);
   assign reg_wr_addr       = t_ptr;
   assign reg_wr_data       = (state == RUN) ? alu_result : 8'h00;
   assign reg_rd_addr_a     = a_ptr;
   assign reg_rd_addr_b     = b_ptr;
   assign stage4_exec_ready = ready_q;
   assign stage4_carry      = carry_q;
   assign stage4_zero       = zero_q;
   assign stage4_error      = error_q;

endmodule
